// File: rtl/regfile_mp.sv
// regfile_mp: two write ports, NUM_RD read ports, r0 hardwired zero, post-reset clear sequencer; REGFILE_WCOLL_EN adds a collision flag.
// Reads are 0-cycle with same-cycle write bypass; no backpressure, ready=0 (all reads 0) while clearing.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wAddr0,
  input  logic [DATA_W-1:0]        wData0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wAddr1,
  input  logic [DATA_W-1:0]        wData1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] rAddr,
  output logic [NUM_RD*DATA_W-1:0] rData,
  output logic                     wColl
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clrPtr;
  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= CLEAR;
      clrPtr <= ADDR_W'(1);
      ready  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          regs[clrPtr] <= '0;
          if (clrPtr == LAST) begin
            state <= READY;
            ready <= 1'b1;
          end else begin
            clrPtr <= clrPtr + ADDR_W'(1);
          end
        end
        READY: begin
          // Port 1 is assigned last so it wins an address tie.
          if (we0 && wAddr0 != '0) regs[wAddr0] <= wData0;
          if (we1 && wAddr1 != '0) regs[wAddr1] <= wData1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

`ifdef REGFILE_WCOLL_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wColl <= 1'b0;
    end else begin
      wColl <= (state == READY) && we0 && we1 && (wAddr0 == wAddr1) && (wAddr0 != '0);
    end
  end
`else
  assign wColl = 1'b0;
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = rAddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      if (ready && ra != '0 && re[i]) begin
        if (we1 && wAddr1 == ra)      rd = wData1;
        else if (we0 && wAddr0 == ra) rd = wData0;
        else                          rd = regs[ra];
      end
    end

    assign rData[i*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp (4 read lanes) against an array-based reference model.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          we0, we1;
  logic [AW-1:0] wAddr0, wAddr1;
  logic [DW-1:0] wData0, wData1;
  logic [NR-1:0] re;
  logic [NR*AW-1:0] rAddr;
  logic [NR*DW-1:0] rData;
  logic          wColl;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [DEPTH];
  bit            mready;
  int            clr_cnt;
  bit            mcoll;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .we0(we0), .wAddr0(wAddr0), .wData0(wData0),
    .we1(we1), .wAddr1(wAddr1), .wData1(wData1),
    .re(re), .rAddr(rAddr), .rData(rData), .wColl(wColl)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int i);
    logic [AW-1:0] a;
    a = rAddr[i*AW +: AW];
    if (!mready || a == 0 || !re[i]) return '0;
    if (we1 && wAddr1 == a) return wData1;
    if (we0 && wAddr0 == a) return wData0;
    return mem[a];
  endfunction

  task automatic check_all(input string tag);
    chk($sformatf("%s/ready", tag), DW'(ready), DW'(mready));
    chk($sformatf("%s/wColl", tag), DW'(wColl), DW'(mcoll));
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s/lane%0d", tag, i), rData[i*DW +: DW], exp_rd(i));
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      mready  = 0;
      clr_cnt = 0;
      mcoll   = 0;
    end else if (!mready) begin
      mcoll = 0;
      clr_cnt++;
      if (clr_cnt == DEPTH - 1) begin
        mready = 1;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
      end
    end else begin
`ifdef REGFILE_WCOLL_EN
      mcoll = we0 && we1 && wAddr0 == wAddr1 && wAddr0 != 0;
`else
      mcoll = 0;
`endif
      if (we0 && wAddr0 != 0) mem[wAddr0] = wData0;
      if (we1 && wAddr1 != 0) mem[wAddr1] = wData1;
    end
    #1;
  endtask

  task automatic settle(input string tag);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; re = '0; rAddr = '0;
    wAddr0 = '0; wAddr1 = '0; wData0 = '0; wData1 = '0;
  endtask

  task automatic setrd(input int i, input int a);
    rAddr[i*AW +: AW] = AW'(a);
  endtask

  task automatic randomize_inputs(input bit narrow);
    we0    = 1'($urandom_range(0, 1));
    we1    = 1'($urandom_range(0, 1));
    wAddr0 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
    wAddr1 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
    wData0 = $urandom;
    wData1 = $urandom;
    re     = NR'($urandom);
    for (int i = 0; i < NR; i++)
      setrd(i, narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1)));
  endtask

  initial begin
    mready = 0; clr_cnt = 0; mcoll = 0;
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    idle();
    rst = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      settle("rst");
      tick();
    end
    rst = 1;

    // Clear: writes and reads attempted during it must have no effect.
    for (int k = 0; k < DEPTH - 1; k++) begin
      randomize_inputs(0);
      settle("clear");
      chk("clear/not_ready", DW'(ready), '0);
      tick();
    end
    idle();
    settle("after_clear");
    chk("ready_after_31", DW'(ready), DW'(1));
    tick();

    for (int a = 0; a < DEPTH; a++) begin
      re = '1;
      for (int i = 0; i < NR; i++) setrd(i, a);
      settle("sweep");
      chk($sformatf("sweep_r%0d", a), rData[DW-1:0], '0);
      tick();
    end

    idle();
    we0 = 1; wAddr0 = 5; wData0 = 32'hDEADBEEF; re = 4'b0001; setrd(0, 5);
    settle("byp5");
    chk("bypass_r5", rData[DW-1:0], 32'hDEADBEEF);
    tick();
    we0 = 0;
    settle("st5");
    chk("stored_r5", rData[DW-1:0], 32'hDEADBEEF);
    tick();

    idle();
    we0 = 1; wAddr0 = 7; wData0 = 32'h11111111;
    we1 = 1; wAddr1 = 7; wData1 = 32'h22222222;
    re = 4'b0001; setrd(0, 7);
    settle("coll");
    chk("coll_bypass_r7", rData[DW-1:0], 32'h22222222);
    tick();
    we0 = 0; we1 = 0;
    settle("coll+1");
    chk("coll_stored_r7", rData[DW-1:0], 32'h22222222);
`ifdef REGFILE_WCOLL_EN
    chk("wcoll_pulse", DW'(wColl), DW'(1));
`else
    chk("wcoll_pulse", DW'(wColl), '0);
`endif
    tick();
    settle("coll+2");
    chk("wcoll_one_cycle", DW'(wColl), '0);
    tick();

    idle();
    we1 = 1; wAddr1 = 0; wData1 = 32'hFFFFFFFF; re = '1;
    settle("w0");
    chk("r0_write_cycle", rData[3*DW +: DW], '0);
    tick();
    we1 = 0;
    settle("w0+1");
    chk("r0_after", rData[DW-1:0], '0);
    tick();

    idle();
    we0 = 1; wAddr0 = 1; wData0 = 32'h1; we1 = 1; wAddr1 = 9; wData1 = 32'h9;
    settle("w1w9");
    tick();
    idle();
    re = 4'b1011; setrd(0, 1); setrd(1, 1); setrd(2, 0); setrd(3, 9);
    settle("lanes");
    chk("lane0_r1", rData[0*DW +: DW], 32'h1);
    chk("lane1_r1", rData[1*DW +: DW], 32'h1);
    chk("lane2_off", rData[2*DW +: DW], 32'h0);
    chk("lane3_r9", rData[3*DW +: DW], 32'h9);
    tick();

    idle();
    we0 = 1; wAddr0 = 3; wData0 = 32'hA5A5A5A5;
    settle("w3");
    tick();
    rst = 0; we0 = 1; wAddr0 = 4; wData0 = 32'h44444444;
    settle("midrst");
    tick();
    rst = 1; idle();
    settle("midrst+1");
    chk("ready_dropped", DW'(ready), '0);
    tick();
    for (int k = 0; k < DEPTH - 2; k++) begin
      settle("clear2");
      tick();
    end
    idle(); re = 4'b0011; setrd(0, 3); setrd(1, 4);
    settle("post_rst");
    chk("post_rst_ready", DW'(ready), DW'(1));
    chk("post_rst_r3", rData[0*DW +: DW], '0);
    chk("post_rst_r4", rData[1*DW +: DW], '0);
    tick();

    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) != 0);
      randomize_inputs(($urandom_range(0, 1) == 1));
      settle("rand");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the single-write, two-read file in the decode stage.
- Configurable data width, depth and read-port count.
- Two write ports, so the write-back stage can retire two results per cycle.
- Same-cycle write-to-read bypass.
- Post-reset hardware clear sequencer, so no register ever reads X.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of independent read ports (1..4)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low (0 at a rising clk edge = reset)
ready  out  1  1 = clear sequence finished, file operational
we0  in  1  write enable, port 0
wAddr0  in  ADDR_W  write address, port 0
wData0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wAddr1  in  ADDR_W  write address, port 1
wData1  in  DATA_W  write data, port 1
re  in  NUM_RD  per-port read enable; bit i belongs to read port i
rAddr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rData  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
wColl  out  1  write-collision flag (see Optional Feature)

Behaviour:
- Register 0 is hardwired zero: never written, always reads 0.
- State machine: CLEAR, READY.
- rst=0 at an edge:
  - state <= CLEAR, clrPtr <= 1, ready <= 0, wColl <= 0.
  - Same behaviour when asserted mid-operation: any write in that cycle is discarded.
- CLEAR (rst=1):
  - Each edge: regs[clrPtr] <= 0, clrPtr <= clrPtr+1.
  - When clrPtr == DEPTH-1 is written: state <= READY, ready <= 1.
  - Clear takes DEPTH-1 cycles after rst rises (31 for defaults); ready is 1 from the edge that clears the last register.
  - we0/we1 are ignored.
  - All rData lanes return 0.
- READY: writes at the edge.
  - If weN=1 and wAddrN!=0: regs[wAddrN] <= wDataN.
  - we0 and we1 both high with equal nonzero addresses: port 1 data stored, port 0 dropped.
  - Writes to address 0 are dropped silently.
- Read lane i, combinational, priority order:
  1. ready=0 -> 0
  2. rAddr_i == 0 -> 0
  3. re[i] = 0 -> 0
  4. we1=1 and wAddr1 == rAddr_i -> wData1 (bypass)
  5. we0=1 and wAddr0 == rAddr_i -> wData0 (bypass)
  6. otherwise -> regs[rAddr_i]
- Read latency: 0 cycles. Write latency: visible to reads in the same cycle through bypass, and from storage from the next cycle.
- Lanes are fully independent; any number of lanes may read the same address.
- Widths: all comparisons are ADDR_W bits wide with no sign extension; clrPtr is ADDR_W bits and never wraps, because the FSM leaves CLEAR at DEPTH-1.
- Reset values:
  - ready = 0
  - wColl = 0
  - rData = 0 (forced via the ready=0 rule)
  - Register contents are undefined until CLEAR completes.

Optional Feature:
- Macro: REGFILE_WCOLL_EN.
- Defined:
  - wColl is registered.
  - Set to 1 at an edge where state is READY, rst=1, we0=we1=1 and wAddr0 == wAddr1 != 0.
  - Otherwise <= 0 at each edge (a one-cycle pulse the cycle after the collision).
  - Used by the issue-logic assertion checker.
- Not defined:
  - wColl is tied constant 0.
  - No collision-detect logic is built.
  - The port stays in the list so instantiations do not change.

Test Plan:
1. Hold rst=0 for 3 cycles, then release -> ready=0 for 31 edges and 1 from the 31st edge; rData = 0 throughout; afterwards every address reads 0x00000000 with re=all 1s.
2. After ready: we0=1, wAddr0=5, wData0=0xDEADBEEF, with rAddr lane0=5, re=1 in the same cycle -> lane0 = 0xDEADBEEF in that cycle (bypass) and on the following cycle with we0=0 (stored).
3. we0=1/wAddr0=7/wData0=0x11111111 and we1=1/wAddr1=7/wData1=0x22222222 in the same cycle -> bypass and later reads of r7 give 0x22222222. With REGFILE_WCOLL_EN, wColl=1 for exactly the next cycle; without it, wColl stays 0.
4. we1=1, wAddr1=0, wData1=0xFFFFFFFF; then read address 0 on all lanes with re=1 -> all lanes 0, in the write cycle and after.
5. Write r3=0xA5A5A5A5, then pull rst=0 for one edge while we0=1/wAddr0=4 -> ready drops the next cycle, the r4 write is lost, and after the 31-cycle clear both r3 and r4 read 0.
6. NUM_RD=4: lanes 0..3 read r1, r1, r0, r9 with re=1011b (lane 2 disabled), r1=0x1, r9=0x9 -> rData lanes 0x1, 0x1, 0x0, 0x9.
